// File: rtl/vdp_bus_sync.sv
// vdp_bus_sync: synchronizes Z8S180 I/O strobes into pxclk and issues one-cycle vdp99 ticks.
// Define VDP_BUS_WAIT_EN to stretch CPU cycles with WAIT until the access is serviced.
module vdp_bus_sync #(
  parameter logic [7:0] BASE_PORT = 8'h80
) (
  input  logic       pxclk,
  input  logic       reset,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_dout_oe,
  output logic       cpu_wait_n,
  output logic       wr_tick,
  output logic       rd_tick,
  output logic       mode,
  output logic [7:0] din,
  input  logic [7:0] vdp_dout
);
  typedef enum logic [2:0] {IDLE, RD_TICK, RD_HOLD, WR_TICK, WR_HOLD, BAD_HOLD} state_t;
  state_t r_state, w_next;
  logic r_iorq_s1, r_iorq_s2, r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2;
  logic [1:0] r_settle;
  logic [7:0] r_din, r_rd_data;
  logic r_mode;
  logic w_match, w_sel_s, w_busy, w_armed, w_release;
  assign w_match   = cpu_addr[7:1] == BASE_PORT[7:1];
  assign w_sel_s   = r_iorq_s2 && w_match && (r_rd_s2 ^ r_wr_s2);
  assign w_busy    = r_iorq_s2 && w_match && (r_rd_s2 || r_wr_s2);
  assign w_release = !r_iorq_s2 || (!r_rd_s2 && !r_wr_s2);
  // Not armed until the synchronizers hold live values after reset, so a strobe
  // still held across reset parks in BAD_HOLD instead of ticking.
  assign w_armed   = &r_settle;
  always_ff @(posedge pxclk or posedge reset)
    if (reset) begin
      {r_iorq_s1, r_iorq_s2, r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2} <= '0;
      r_settle  <= '0;
      r_din     <= '0;
      r_mode    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      {r_iorq_s1, r_rd_s1, r_wr_s1} <= {!cpu_iorq_n, !cpu_rd_n, !cpu_wr_n};
      {r_iorq_s2, r_rd_s2, r_wr_s2} <= {r_iorq_s1, r_rd_s1, r_wr_s1};
      r_settle <= w_armed ? r_settle : r_settle + 2'd1;
      if (w_next == WR_TICK) r_din <= cpu_din;
      if (w_next == WR_TICK || w_next == RD_TICK) r_mode <= cpu_addr[0];
      if (r_state == RD_TICK) r_rd_data <= vdp_dout;
    end
  always_ff @(posedge pxclk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_busy ? IDLE : (!w_armed || !w_sel_s) ? BAD_HOLD : r_rd_s2 ? RD_TICK : WR_TICK;
      RD_TICK: w_next = RD_HOLD;
      WR_TICK: w_next = WR_HOLD;
      default: w_next = w_release ? IDLE : r_state;
    endcase
  end
  assign wr_tick     = r_state == WR_TICK;
  assign rd_tick     = r_state == RD_TICK;
  assign mode        = r_mode;
  assign din         = r_din;
  assign cpu_dout    = r_rd_data;
  assign cpu_dout_oe = r_state == RD_HOLD && !cpu_iorq_n && !cpu_rd_n && w_match;
`ifdef VDP_BUS_WAIT_EN
  logic w_sel_raw;
  assign w_sel_raw  = !cpu_iorq_n && w_match && (!cpu_rd_n ^ !cpu_wr_n);
  assign cpu_wait_n = !(w_sel_raw && r_state != RD_HOLD && r_state != WR_HOLD);
`else
  assign cpu_wait_n = 1'b1;
`endif
endmodule

// File: tb/tb_vdp_bus_sync.sv
// tb_vdp_bus_sync: directed and random CPU I/O cycles checked against a transaction-level model.
module tb_vdp_bus_sync;
`ifdef VDP_BUS_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif
  logic pxclk = 1'b0, reset = 1'b1;
  logic cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [7:0] cpu_addr = 8'h00, cpu_din = 8'h00, vdp_dout = 8'h00;
  logic [7:0] cpu_dout, din;
  logic cpu_dout_oe, cpu_wait_n, wr_tick, rd_tick, mode;
  int checks = 0, errors = 0;
  logic exp_mode = 1'b0;
  logic [7:0] exp_din = 8'h00, exp_rd = 8'h00;

  vdp_bus_sync dut (
    .pxclk(pxclk), .reset(reset), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_dout_oe(cpu_dout_oe), .cpu_wait_n(cpu_wait_n), .wr_tick(wr_tick),
    .rd_tick(rd_tick), .mode(mode), .din(din), .vdp_dout(vdp_dout)
  );

  always #5 pxclk = ~pxclk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic release_bus();
    @(negedge pxclk);
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    #1;
    chk("oe_release", {7'd0, cpu_dout_oe}, 8'h00);
    chk("wait_release", {7'd0, cpu_wait_n}, 8'h01);
    repeat (4) begin
      @(negedge pxclk);
      chk("tick_gap", {6'd0, wr_tick, rd_tick}, 8'h00);
      chk("dout_gap", cpu_dout, exp_rd);
    end
  endtask

  // Sample c is taken on the falling edge after E(c-1); the strobe asserts just before E0.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] v, input int hold);
    logic hit, pm;
    logic [7:0] pd, pr;
    hit = (a[7:1] == 7'h40) && (rd ^ wr);
    pm = exp_mode; pd = exp_din; pr = exp_rd;
    if (hit) begin
      exp_mode = a[0];
      if (wr) exp_din = d;
      else exp_rd = v;
    end
    @(negedge pxclk);
    cpu_addr = a; cpu_din = d; vdp_dout = v;
    cpu_iorq_n = 1'b0; cpu_rd_n = !rd; cpu_wr_n = !wr;
    #1 chk("wait_select", {7'd0, cpu_wait_n}, {7'd0, WAIT ? !hit : 1'b1});
    for (int c = 1; c <= hold; c++) begin
      @(negedge pxclk);
      chk("wr_tick", {7'd0, wr_tick}, {7'd0, hit && wr && c == 3});
      chk("rd_tick", {7'd0, rd_tick}, {7'd0, hit && rd && c == 3});
      chk("mode", {7'd0, mode}, {7'd0, c >= 3 ? exp_mode : pm});
      chk("din", din, c >= 3 ? exp_din : pd);
      chk("cpu_dout", cpu_dout, c >= 4 ? exp_rd : pr);
      chk("dout_oe", {7'd0, cpu_dout_oe}, {7'd0, hit && rd && c >= 4});
      chk("wait_n", {7'd0, cpu_wait_n}, {7'd0, WAIT ? !(hit && c <= 3) : 1'b1});
      if (c == 4) vdp_dout = 8'($urandom);
    end
    release_bus();
  endtask

  initial begin
    logic [7:0] a;
    int kind;
    @(negedge pxclk);
    chk("rst_wr_tick", {7'd0, wr_tick}, 8'h00);
    chk("rst_rd_tick", {7'd0, rd_tick}, 8'h00);
    chk("rst_mode", {7'd0, mode}, 8'h00);
    chk("rst_din", din, 8'h00);
    chk("rst_dout", cpu_dout, 8'h00);
    chk("rst_oe", {7'd0, cpu_dout_oe}, 8'h00);
    chk("rst_wait", {7'd0, cpu_wait_n}, 8'h01);
    reset = 1'b0;
    repeat (4) @(negedge pxclk);

    access(1'b0, 1'b1, 8'h81, 8'h5A, 8'h00, 8);
    access(1'b1, 1'b0, 8'h80, 8'h00, 8'hC3, 7);
    access(1'b1, 1'b0, 8'h82, 8'h00, 8'h77, 7);
    access(1'b0, 1'b1, 8'h82, 8'hEE, 8'h00, 7);
    access(1'b1, 1'b1, 8'h80, 8'h99, 8'h66, 7);
    access(1'b0, 1'b1, 8'h80, 8'h24, 8'h00, 6);

    // Reset lands on E2 of a write; the strobe stays low afterwards.
    @(negedge pxclk);
    cpu_addr = 8'h81; cpu_din = 8'h3C; vdp_dout = 8'h00;
    cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0; cpu_rd_n = 1'b1;
    repeat (2) @(negedge pxclk);
    reset = 1'b1;
    exp_mode = 1'b0; exp_din = 8'h00; exp_rd = 8'h00;
    #1;
    chk("rreset_wr_tick", {7'd0, wr_tick}, 8'h00);
    chk("rreset_din", din, 8'h00);
    chk("rreset_mode", {7'd0, mode}, 8'h00);
    chk("rreset_dout", cpu_dout, 8'h00);
    @(negedge pxclk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge pxclk);
      chk("held_tick", {6'd0, wr_tick, rd_tick}, 8'h00);
      chk("held_din", din, 8'h00);
      chk("held_wait", {7'd0, cpu_wait_n}, {7'd0, !WAIT});
    end
    release_bus();
    access(1'b0, 1'b1, 8'h81, 8'hA5, 8'h00, 6);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = {7'h40, 1'($urandom)};
      if (kind == 3) begin
        a = 8'($urandom);
        while (a[7:1] == 7'h40) a = 8'($urandom);
      end
      access(kind == 1 || kind == 2 || (kind == 3 && 1'($urandom)), kind == 0 || kind == 2 || kind == 3,
             a, 8'($urandom), 8'($urandom), $urandom_range(5, 9));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
